// File: rtl/clock_pkg.sv
// Shared mode codes, counter widths and helpers for the clock time-setting controller.
package clock_pkg;

    localparam int unsigned MODE_W            = 2;
    localparam int unsigned IDLE_W            = 8;
    localparam int unsigned REP_W             = 4;
    localparam int unsigned DIV_W             = 3;
    localparam int unsigned TIMEOUT_S_DEFAULT = 20;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN  = 2'd0,
        MODE_SEC  = 2'd1,
        MODE_MIN  = 2'd2,
        MODE_HOUR = 2'd3
    } mode_e;

    // Next mode in the MODE button cycle: RUN -> SEC -> MIN -> HOUR -> RUN.
    function automatic mode_e mode_advance(input mode_e m);
        case (m)
            MODE_RUN: return MODE_SEC;
            MODE_SEC: return MODE_MIN;
            MODE_MIN: return MODE_HOUR;
            default:  return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level.
//   clk, rst : clock, synchronous active-high reset
//   lvl      : debounced level, 1 = pressed
//   press    : 1 while lvl is high and the previous level was low (combinational)
// The previous-level register resets to 1 so a button held through reset never
// produces a press.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic press
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= lvl;
    end

    assign press = lvl & ~prev;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the digital clock: mode sequencing, field
// increment pulses with auto-repeat, inactivity timeout, freeze and blink.
//   clk, rst            : clock, synchronous active-high reset
//   tick_1hz, tick_8hz  : one-cycle timing strobes
//   btn_mode, btn_up    : debounced button levels
//   mode                : 0 RUN, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR
//   inc_sec/min/hour    : one-cycle increment pulses to the time counters
//   freeze              : timekeeping counters hold while set
//   blank               : blank the selected field (blink)
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S  = TIMEOUT_S_DEFAULT,
    parameter int unsigned REPEAT_DLY = 4,
    parameter int unsigned BLINK_DIV  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              tick_8hz,
    input  logic              btn_mode,
    input  logic              btn_up,
    output logic [MODE_W-1:0] mode,
    output logic              inc_sec,
    output logic              inc_min,
    output logic              inc_hour,
    output logic              freeze,
    output logic              blank
);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);
    localparam logic [REP_W-1:0]  REP_FULL  = REP_W'(REPEAT_DLY);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BLINK_DIV - 1);

    logic mode_p;
    logic up_p;

    btn_edge u_mode_edge (.clk(clk), .rst(rst), .lvl(btn_mode), .press(mode_p));
    btn_edge u_up_edge   (.clk(clk), .rst(rst), .lvl(btn_up),   .press(up_p));

    mode_e             state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              arm_q, arm_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              phase_q, phase_d;
    logic              inc_sec_d, inc_min_d, inc_hour_d, freeze_d, blank_d;

    logic in_set, rep_pulse, activity, timeout, fire;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        idle_d     = idle_q;
        rep_d      = rep_q;
        arm_d      = arm_q;
        div_d      = div_q;
        phase_d    = phase_q;

        in_set     = (state_q != MODE_RUN);
        // Auto-repeat only for a hold that started with a press in the current set mode.
        rep_pulse  = in_set && arm_q && btn_up && tick_8hz && (rep_q == REP_FULL);
        activity   = up_p || rep_pulse;
        // Any activity on the timeout tick restarts the inactivity window.
        timeout    = in_set && tick_1hz && (idle_q == IDLE_LAST) && !activity;
        fire       = in_set && !mode_p && activity;

        if (mode_p)       state_d = mode_advance(state_q);
        else if (timeout) state_d = MODE_RUN;

        if (state_d == MODE_RUN || mode_p || activity) idle_d = '0;
        else if (tick_1hz)                              idle_d = idle_q + IDLE_W'(1);

        // Any mode change disarms repeat; UP must be released and pressed again.
        if (mode_p || state_d != state_q || state_d == MODE_RUN || !btn_up) begin
            rep_d = '0;
            arm_d = 1'b0;
        end else if (up_p) begin
            rep_d = '0;
            arm_d = 1'b1;
        end else if (arm_q && tick_8hz && rep_q != REP_FULL) begin
            rep_d = rep_q + REP_W'(1);
        end

        // Field shows solid right after entering a set mode or changing its value.
        if (mode_p || state_d == MODE_RUN || fire) begin
            div_d   = '0;
            phase_d = 1'b0;
        end else if (tick_8hz) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                phase_d = ~phase_q;
            end else begin
                div_d   = div_q + DIV_W'(1);
            end
        end

        inc_sec_d  = fire && (state_q == MODE_SEC);
        inc_min_d  = fire && (state_q == MODE_MIN);
        inc_hour_d = fire && (state_q == MODE_HOUR);
        freeze_d   = (state_d != MODE_RUN);
        blank_d    = phase_d && (state_d != MODE_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MODE_RUN;
            idle_q   <= '0;
            rep_q    <= '0;
            arm_q    <= 1'b0;
            div_q    <= '0;
            phase_q  <= 1'b0;
            inc_sec  <= 1'b0;
            inc_min  <= 1'b0;
            inc_hour <= 1'b0;
            freeze   <= 1'b0;
            blank    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            rep_q    <= rep_d;
            arm_q    <= arm_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            inc_sec  <= inc_sec_d;
            inc_min  <= inc_min_d;
            inc_hour <= inc_hour_d;
            freeze   <= freeze_d;
            blank    <= blank_d;
        end
    end

    assign mode = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: a table of single-cycle vectors plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_8hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic [1:0] mode;
    logic       inc_sec, inc_min, inc_hour, freeze, blank;

    clock_set_ctrl #(.TIMEOUT_S(20), .REPEAT_DLY(4), .BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_8hz(tick_8hz),
        .btn_mode(btn_mode), .btn_up(btn_up), .mode(mode),
        .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour),
        .freeze(freeze), .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] md;
        logic s, m, h, frz, blk;
        string name;
    } exp_t;

    typedef struct {
        logic r, bm, bu, t1, t8;
        logic [1:0] md;
        logic s, m, h, blk;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   hour_pulses;

    task automatic add(input logic r, bm, bu, t1, t8,
                       input logic [1:0] md, input logic s, m, h, blk);
        vec_t v;
        v.r = r; v.bm = bm; v.bu = bu; v.t1 = t1; v.t8 = t8;
        v.md = md; v.s = s; v.m = m; v.h = h; v.blk = blk;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs (at negedge), then check registered outputs at the next negedge.
    task automatic cyc(input logic r, bm, bu, t1, t8,
                       input logic [1:0] md, input logic s, m, h, blk, input string name);
        exp_t e, g;
        rst = r; btn_mode = bm; btn_up = bu; tick_1hz = t1; tick_8hz = t8;
        e.md = md; e.s = s; e.m = m; e.h = h; e.frz = (md != 2'd0); e.blk = blk; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        g = sb.pop_front();
        n_total++;
        if (mode === g.md && inc_sec === g.s && inc_min === g.m && inc_hour === g.h &&
            freeze === g.frz && blank === g.blk) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got mode=%0d inc(s,m,h)=%b%b%b freeze=%b blank=%b, want mode=%0d inc=%b%b%b freeze=%b blank=%b",
                     g.name, $time, mode, inc_sec, inc_min, inc_hour, freeze, blank,
                     g.md, g.s, g.m, g.h, g.frz, g.blk);
        end
    endtask

    // Plain cycle shorthand: no reset, no strobes.
    task automatic btn(input logic bm, bu, input logic [1:0] md,
                       input logic s, m, h, input string name);
        cyc(1'b0, bm, bu, 1'b0, 1'b0, md, s, m, h, 1'b0, name);
    endtask

    initial begin
        @(negedge clk);

        // r bm bu t1 t8 | mode s m h blk
        add(1,1,0,0,0, 0,0,0,0,0);
        add(1,1,0,0,0, 0,0,0,0,0);
        add(1,1,0,0,0, 0,0,0,0,0);
        add(0,1,0,0,0, 0,0,0,0,0);   // held through reset: no press
        add(0,1,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0, 0,0,0,0,0);
        add(0,1,0,0,0, 1,0,0,0,0);
        add(0,1,0,0,0, 1,0,0,0,0);
        add(0,0,0,0,0, 1,0,0,0,0);
        add(0,1,0,0,0, 2,0,0,0,0);
        add(0,0,0,0,0, 2,0,0,0,0);
        add(0,1,0,0,0, 3,0,0,0,0);
        add(0,0,0,0,0, 3,0,0,0,0);
        add(0,1,0,0,0, 0,0,0,0,0);   // wrap to RUN
        add(0,0,0,0,0, 0,0,0,0,0);
        add(0,0,1,0,0, 0,0,0,0,0);   // UP ignored in RUN
        add(0,0,0,0,0, 0,0,0,0,0);
        add(0,1,0,0,0, 1,0,0,0,0);
        add(0,0,0,0,0, 1,0,0,0,0);
        add(0,1,0,0,0, 2,0,0,0,0);
        add(0,0,0,0,0, 2,0,0,0,0);
        add(0,0,1,0,0, 2,0,1,0,0);   // single UP -> one inc_min
        add(0,0,0,0,0, 2,0,0,0,0);
        add(0,0,0,0,1, 2,0,0,0,0);   // blink: toggles on 4th tick_8hz
        add(0,0,0,0,1, 2,0,0,0,0);
        add(0,0,0,0,1, 2,0,0,0,0);
        add(0,0,0,0,1, 2,0,0,0,1);
        add(0,0,0,0,0, 2,0,0,0,1);
        add(0,0,0,0,1, 2,0,0,0,1);
        add(0,0,0,0,1, 2,0,0,0,1);
        add(0,0,0,0,1, 2,0,0,0,1);
        add(0,0,0,0,1, 2,0,0,0,0);
        add(0,0,0,0,1, 2,0,0,0,0);
        add(0,0,0,0,1, 2,0,0,0,0);
        add(0,0,0,0,1, 2,0,0,0,0);
        add(0,0,0,0,1, 2,0,0,0,1);   // phase up again
        add(0,1,0,0,0, 3,0,0,0,0);   // mode change makes field visible
        add(0,0,0,0,0, 3,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i].r, tbl[i].bm, tbl[i].bu, tbl[i].t1, tbl[i].t8,
                tbl[i].md, tbl[i].s, tbl[i].m, tbl[i].h, tbl[i].blk, "table");

        // Auto-repeat in SET_HOUR: 1 press pulse + 12 repeat pulses over 16 ticks.
        hour_pulses = 0;
        btn(0, 1, 3, 0, 0, 1, "hold_press");
        hour_pulses += int'(inc_hour);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 0, 1, 0, 1, 3, 0, 0, (k >= 5), (k == 4), "hold_tick");
            hour_pulses += int'(inc_hour);
            cyc(0, 0, 1, 0, 0, 3, 0, 0, 0, (k == 4), "hold_gap");
            hour_pulses += int'(inc_hour);
        end
        btn(0, 0, 3, 0, 0, 0, "hold_release");
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, "after_release");
            hour_pulses += int'(inc_hour);
        end
        n_total++;
        if (hour_pulses == 13) n_pass++;
        else $display("FAIL hold_count: got %0d inc_hour pulses, want 13", hour_pulses);

        // Timeout: to SET_SEC, then RUN on the cycle after the 20th tick_1hz.
        btn(1, 0, 0, 0, 0, 0, "to_run");
        btn(0, 0, 0, 0, 0, 0, "to_run_rel");
        btn(1, 0, 1, 0, 0, 0, "to_sec");
        btn(0, 0, 1, 0, 0, 0, "to_sec_rel");
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 0, 1, 0, (k == 20) ? 2'd0 : 2'd1, 0, 0, 0, 0, "timeout_tick");
            cyc(0, 0, 0, 0, 0, (k == 20) ? 2'd0 : 2'd1, 0, 0, 0, 0, "timeout_gap");
        end

        // UP press after 15 ticks restarts the 20-tick window.
        btn(1, 0, 1, 0, 0, 0, "re_sec");
        btn(0, 0, 1, 0, 0, 0, "re_sec_rel");
        for (int k = 1; k <= 15; k++)
            cyc(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, "pre_press_tick");
        btn(0, 1, 1, 1, 0, 0, "up_at_15");
        btn(0, 0, 1, 0, 0, 0, "up_rel");
        for (int k = 1; k <= 20; k++)
            cyc(0, 0, 0, 1, 0, (k == 20) ? 2'd0 : 2'd1, 0, 0, 0, 0, "post_press_tick");

        // MODE and UP rising together: advance only, and the held UP never repeats.
        btn(1, 0, 1, 0, 0, 0, "sim_to_sec");
        btn(0, 0, 1, 0, 0, 0, "sim_rel");
        btn(1, 1, 2, 0, 0, 0, "mode_and_up");
        btn(0, 1, 2, 0, 0, 0, "up_held");
        for (int k = 0; k < 6; k++)
            cyc(0, 0, 1, 0, (k % 2 == 0), 2, 0, 0, 0, 0, "held_after_mode");
        btn(0, 0, 2, 0, 0, 0, "up_rel2");

        // MODE press on the timeout tick: advance wins.
        btn(1, 0, 3, 0, 0, 0, "adv_hour");
        btn(0, 0, 3, 0, 0, 0, "adv_rel");
        btn(1, 0, 0, 0, 0, 0, "adv_run");
        btn(0, 0, 0, 0, 0, 0, "adv_rel");
        btn(1, 0, 1, 0, 0, 0, "adv_sec");
        btn(0, 0, 1, 0, 0, 0, "adv_rel");
        for (int k = 1; k <= 19; k++)
            cyc(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, "pre_timeout_tick");
        cyc(0, 1, 0, 1, 0, 2, 0, 0, 0, 0, "mode_on_timeout");
        btn(0, 0, 2, 0, 0, 0, "after_mode_on_timeout");

        // Reset mid-operation with UP rising: RUN, no inc.
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "reset_mid");
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
